// File: rtl/roic_wait_sync_gen.sv
// Sequencer-launched ROIC sync / test-pulse select waveform generator.
// One launch produces a sync pulse, an optional delayed TP window, and a holdoff gap.
module roic_wait_sync_gen #(
    parameter int CNT_W = 16
) (
    input  logic             clk_20mhz,
    input  logic             rst_n_20mhz,
    input  logic             wait_start,
    input  logic             wait_abort,
    input  logic [7:0]       cfg_sync_width,
    input  logic             cfg_tp_en,
    input  logic [CNT_W-1:0] cfg_tp_delay,
    input  logic [CNT_W-1:0] cfg_tp_width,
    input  logic [7:0]       cfg_holdoff,
    output logic             fsm_wait_roic_sync,
    output logic             fsm_wait_tp_sel,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             start_ignored
);

    // Counter must hold both the 8-bit sync/holdoff lengths and the CNT_W TP lengths.
    localparam int CW = (CNT_W > 8) ? CNT_W : 8;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        TP_DELAY,
        TP_ACT,
        HOLDOFF
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             cnt_last;

    logic             tp_en_reg;
    logic [CNT_W-1:0] tp_delay_reg;
    logic [CNT_W-1:0] tp_width_reg;
    logic [7:0]       holdoff_reg;
    logic             accept_start;

    logic sync_next, tp_sel_next, busy_next, done_next, aborted_next, ignored_next;

    assign cnt_last     = (cnt_reg == CW'(1));
    assign accept_start = (state_reg == IDLE) && wait_start && !wait_abort;

    always_ff @(posedge clk_20mhz or negedge rst_n_20mhz) begin
        if (!rst_n_20mhz) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            tp_en_reg    <= 1'b0;
            tp_delay_reg <= '0;
            tp_width_reg <= '0;
            holdoff_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept_start) begin
                tp_en_reg    <= cfg_tp_en;
                tp_delay_reg <= cfg_tp_delay;
                tp_width_reg <= cfg_tp_width;
                holdoff_reg  <= cfg_holdoff;
            end
        end
    end

    // Each state's down-counter is loaded on entry and exits when it reads 1.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg - CW'(1);
        case (state_reg)
            IDLE: begin
                cnt_next = cnt_reg;
                if (accept_start) begin
                    state_next = SYNC;
                    cnt_next   = (cfg_sync_width == 8'd0) ? CW'(1) : CW'(cfg_sync_width);
                end
            end
            SYNC: begin
                if (cnt_last) begin
                    if (tp_en_reg && (tp_delay_reg != '0)) begin
                        state_next = TP_DELAY;
                        cnt_next   = CW'(tp_delay_reg);
                    end else if (tp_en_reg) begin
                        state_next = TP_ACT;
                        cnt_next   = (tp_width_reg == '0) ? CW'(1) : CW'(tp_width_reg);
                    end else if (holdoff_reg != 8'd0) begin
                        state_next = HOLDOFF;
                        cnt_next   = CW'(holdoff_reg);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            TP_DELAY: begin
                if (cnt_last) begin
                    state_next = TP_ACT;
                    cnt_next   = (tp_width_reg == '0) ? CW'(1) : CW'(tp_width_reg);
                end
            end
            TP_ACT: begin
                if (cnt_last) begin
                    if (holdoff_reg != 8'd0) begin
                        state_next = HOLDOFF;
                        cnt_next   = CW'(holdoff_reg);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            HOLDOFF: begin
                if (cnt_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if ((state_reg != IDLE) && wait_abort) begin
            state_next = IDLE;
        end
    end

    // Outputs are decoded from the next state and registered, so the mux sees clean flops.
    always_comb begin
        sync_next    = (state_next == SYNC);
        tp_sel_next  = (state_next == TP_ACT);
        busy_next    = (state_next != IDLE);
        done_next    = (state_reg != IDLE) && (state_next == IDLE) && !wait_abort;
        aborted_next = (state_reg != IDLE) && wait_abort;
        ignored_next = (state_reg != IDLE) && wait_start;
    end

    always_ff @(posedge clk_20mhz or negedge rst_n_20mhz) begin
        if (!rst_n_20mhz) begin
            fsm_wait_roic_sync <= 1'b0;
            fsm_wait_tp_sel    <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            aborted            <= 1'b0;
            start_ignored      <= 1'b0;
        end else begin
            fsm_wait_roic_sync <= sync_next;
            fsm_wait_tp_sel    <= tp_sel_next;
            busy               <= busy_next;
            done               <= done_next;
            aborted            <= aborted_next;
            start_ignored      <= ignored_next;
        end
    end

endmodule

// File: doc/roic_wait_sync_gen.md
# roic_wait_sync_gen

Generates the sequencer-driven ROIC control waveforms `fsm_wait_roic_sync` and `fsm_wait_tp_sel` that feed the control signal mux in the `clk_20mhz` domain. A single-cycle `wait_start` strobe from the sequencer launches a programmable sequence: a ROIC sync pulse, an optional test-pulse select window after a delay, and then a holdoff period. The block reports busy, done, abort and dropped-start status back to the sequencer.

## Interface
- CNT_W, 16, width of the TP delay and TP width counters
- clk_20mhz  in  1  system clock
- rst_n_20mhz  in  1  reset, asynchronous, active-low
- wait_start  in  1  one-cycle launch strobe from sequencer
- wait_abort  in  1  level, aborts the sequence in progress
- cfg_sync_width  in  8  sync pulse length in cycles; 0 is treated as 1
- cfg_tp_en  in  1  enables the TP select window
- cfg_tp_delay  in  CNT_W  cycles from sync falling to TP rising; 0 allowed
- cfg_tp_width  in  CNT_W  TP window length in cycles; 0 is treated as 1
- cfg_holdoff  in  8  idle gap before done; 0 allowed
- fsm_wait_roic_sync  out  1  registered sync pulse to the mux
- fsm_wait_tp_sel  out  1  registered TP select to the mux
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse on abort
- start_ignored  out  1  one-cycle pulse when `wait_start` arrives while busy

## Operation
- States: IDLE, SYNC, TP_DELAY, TP_ACT, HOLDOFF.
- IDLE with `wait_start`=1 and `wait_abort`=0 is an accepted start:
  - All `cfg_*` inputs are latched into shadow registers.
  - Next state is SYNC.
  - Configuration changes during a sequence have no effect.
- SYNC runs for max(W,1) cycles. It then goes to:
  - TP_DELAY if `cfg_tp_en`=1 and D>0;
  - TP_ACT if `cfg_tp_en`=1 and D=0;
  - HOLDOFF if `cfg_tp_en`=0 and H>0;
  - IDLE otherwise.
- TP_DELAY runs for D cycles, then goes to TP_ACT.
- TP_ACT runs for max(T,1) cycles, then goes to HOLDOFF if H>0, otherwise IDLE.
- HOLDOFF runs for H cycles, then goes to IDLE.
- Outputs are Moore, decoded from registered state:
  - `fsm_wait_roic_sync`=1 only in SYNC.
  - `fsm_wait_tp_sel`=1 only in TP_ACT.
  - `busy`=1 in any non-IDLE state.
- `done` fires for one cycle on the first IDLE cycle after normal completion.
- `wait_start` in the done cycle is accepted, giving back-to-back sequences with no gap beyond the done cycle.
- Abort:
  - `wait_abort`=1 sampled in any non-IDLE state moves to IDLE on the next edge.
  - All waveform outputs are 0 from that cycle.
  - `aborted`=1 for one cycle; `done` stays 0.
  - In IDLE, abort wins over a coincident `wait_start`: the start is dropped silently, with no `start_ignored` and no `aborted`.
- `wait_start` in any non-IDLE state is ignored. `start_ignored`=1 the following cycle, and the sequence continues unchanged.
- Counters are down-counters loaded on state entry; terminal count is 1.

## Timing
- Reset values: all outputs 0 and state IDLE, applied asynchronously. Reset mid-sequence drops both waveforms immediately with no done or aborted pulse.
- Cycle numbering: `wait_start` is sampled at edge k.
- Sync: `fsm_wait_roic_sync` is high for cycles k+1 .. k+W' (W' = max(W,1)).
- TP: `fsm_wait_tp_sel` is high for cycles k+W'+D+1 .. k+W'+D+T' (T' = max(T,1)).
- Done: cycle k+W'+D+T'+H+1 when TP is enabled; cycle k+W'+H+1 when TP is disabled.
- `busy` is high from k+1 through the last HOLDOFF cycle and low in the done cycle.
- Latency from `wait_start` to sync rising is 1 cycle. From `wait_abort` to outputs low it is 1 cycle.
- Sync and TP are never high in the same cycle.
- Maximum sequence length is 255 + (2^CNT_W − 1) × 2 + 255 cycles. No counter wrap is possible.

## Test plan
- **Basic, TP disabled:** W=3, tp_en=0, H=0, start at k -> sync high k+1..k+3; done at k+4; busy k+1..k+3.
- **Full sequence:** W=2, D=4, T=5, H=3 -> sync k+1..k+2, tp_sel k+7..k+11, done k+15. Changing cfg mid-sequence alters nothing.
- **Zero edge values:** W=0, D=0, T=0, H=0, tp_en=1 -> sync at k+1 only, tp_sel at k+2 only, done at k+3. Then start in the done cycle -> second sync at k+4.
- **Abort in TP_DELAY:** W=2, D=10, abort at k+5 -> outputs low from k+6; aborted pulse at k+6; no done; tp_sel never rises.
- **Collisions:**
  - Start at k+2 while busy -> start_ignored at k+3 and timing unchanged.
  - Start and abort together in IDLE -> stays IDLE with no pulses.
- **Reset mid-TP_ACT:** assert rst_n_20mhz low between edges -> tp_sel, busy and all pulses read 0 immediately. After release, state is IDLE and a new start behaves as in the basic scenario.
